// File: rtl/thread_scheduler.sv
// Per-thread PC owner and round-robin fetch arbiter for a fine-grained multithreaded pipeline.
// Optional per-thread issue counters are enabled with `define SCHED_ISSUE_CNT_EN.
module thread_scheduler #(
  parameter int          N_THREADS  = 8,
  parameter logic [31:0] PC_RESET   = 32'h1000,
  parameter logic [31:0] EXC_VECTOR = 32'h2000,
  parameter int          TID_W      = $clog2(N_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_THREADS-1:0]   stalled,
  input  logic                   miss_en,
  input  logic [TID_W-1:0]       miss_thread,
  input  logic [31:0]            miss_pc,
  input  logic                   fill_en,
  input  logic [N_THREADS-1:0]   wb_pc_en,
  input  logic [31:0]            wb_pc_data,
  input  logic                   exc_en,
  input  logic [TID_W-1:0]       exc_thread,
  // if_valid qualifies if_thread/if_pc; IF has no back-pressure, so a
  // presented fetch is consumed in the cycle it is valid.
  output logic                   if_valid,
  output logic [TID_W-1:0]       if_thread,
  output logic [31:0]            if_pc,
  output logic [32*N_THREADS-1:0] pc_flat,
`ifdef SCHED_ISSUE_CNT_EN
  input  logic [TID_W-1:0]       cnt_sel,
  output logic [31:0]            cnt_val,
`endif
  output logic [N_THREADS-1:0]   waiting
);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT_MEM = 1'b1} thr_state_e;

  thr_state_e           state_q [N_THREADS];
  thr_state_e           state_d [N_THREADS];
  logic [31:0]          pc_q    [N_THREADS];
  logic [31:0]          pc_d    [N_THREADS];
  logic [TID_W-1:0]     rr_q;
  logic [TID_W-1:0]     win;
  logic [TID_W-1:0]     idx;
  logic                 found;
  logic [N_THREADS-1:0] exc_hit;
  logic [N_THREADS-1:0] miss_hit;
  logic [N_THREADS-1:0] eligible;

  always_comb begin
    exc_hit  = '0;
    miss_hit = '0;
    eligible = '0;
    for (int t = 0; t < N_THREADS; t++) begin
      exc_hit[t]  = exc_en  && (exc_thread  == TID_W'(t));
      miss_hit[t] = miss_en && (miss_thread == TID_W'(t));
      eligible[t] = (state_q[t] == ST_RUN) && !stalled[t] && !exc_hit[t]
                    && !miss_hit[t] && !wb_pc_en[t];
    end
  end

  // Search starts just after the last winner; i == N_THREADS wraps back to rr itself.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= N_THREADS; i++) begin
      idx = rr_q + TID_W'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    for (int t = 0; t < N_THREADS; t++) begin
      state_d[t] = state_q[t];
      pc_d[t]    = pc_q[t];
      if (fill_en && state_q[t] == ST_WAIT_MEM) state_d[t] = ST_RUN;
      if (exc_hit[t]) begin
        pc_d[t]    = EXC_VECTOR;
        state_d[t] = ST_RUN;
      end else if (wb_pc_en[t]) begin
        pc_d[t]    = wb_pc_data;
        state_d[t] = ST_RUN;
      end else if (miss_hit[t]) begin
        // A miss is newer than any fill arriving in the same cycle.
        pc_d[t]    = miss_pc;
        state_d[t] = ST_WAIT_MEM;
      end else if (found && win == TID_W'(t)) begin
        pc_d[t]    = pc_q[t] + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < N_THREADS; t++) begin
        state_q[t] <= ST_RUN;
        pc_q[t]    <= PC_RESET;
      end
      rr_q      <= TID_W'(N_THREADS - 1);
      if_valid  <= 1'b0;
      if_thread <= '0;
      if_pc     <= '0;
    end else begin
      for (int t = 0; t < N_THREADS; t++) begin
        state_q[t] <= state_d[t];
        pc_q[t]    <= pc_d[t];
      end
      if_valid <= found;
      if (found) begin
        if_thread <= win;
        if_pc     <= pc_q[win];
        rr_q      <= win;
      end
    end
  end

  always_comb begin
    pc_flat = '0;
    waiting = '0;
    for (int t = 0; t < N_THREADS; t++) begin
      pc_flat[32*t +: 32] = pc_q[t];
      waiting[t]          = (state_q[t] == ST_WAIT_MEM);
    end
  end

`ifdef SCHED_ISSUE_CNT_EN
  logic [31:0] cnt_q [N_THREADS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < N_THREADS; t++) cnt_q[t] <= '0;
      cnt_val <= '0;
    end else begin
      for (int t = 0; t < N_THREADS; t++) begin
        if (found && win == TID_W'(t) && cnt_q[t] != 32'hFFFF_FFFF)
          cnt_q[t] <= cnt_q[t] + 32'd1;
      end
      cnt_val <= cnt_q[cnt_sel];
    end
  end
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed self-checking bench for thread_scheduler (8 threads).
// Covers issue order, stalls, miss/fill, redirects, exceptions and async reset.
module tb_thread_scheduler;
  localparam int N = 8;
  localparam int TW = 3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    stalled;
  logic            miss_en;
  logic [TW-1:0]   miss_thread;
  logic [31:0]     miss_pc;
  logic            fill_en;
  logic [N-1:0]    wb_pc_en;
  logic [31:0]     wb_pc_data;
  logic            exc_en;
  logic [TW-1:0]   exc_thread;
  logic            if_valid;
  logic [TW-1:0]   if_thread;
  logic [31:0]     if_pc;
  logic [32*N-1:0] pc_flat;
  logic [N-1:0]    waiting;
`ifdef SCHED_ISSUE_CNT_EN
  logic [TW-1:0]   cnt_sel;
  logic [31:0]     cnt_val;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc [N];
  int seq [$];

  thread_scheduler #(.N_THREADS(N)) dut (
    .clk(clk), .rst(rst), .stalled(stalled),
    .miss_en(miss_en), .miss_thread(miss_thread), .miss_pc(miss_pc),
    .fill_en(fill_en), .wb_pc_en(wb_pc_en), .wb_pc_data(wb_pc_data),
    .exc_en(exc_en), .exc_thread(exc_thread),
    .if_valid(if_valid), .if_thread(if_thread), .if_pc(if_pc),
    .pc_flat(pc_flat),
`ifdef SCHED_ISSUE_CNT_EN
    .cnt_sel(cnt_sel), .cnt_val(cnt_val),
`endif
    .waiting(waiting)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    for (int t = 0; t < N; t++) exp_pc[t] = 32'h1000;
  endtask

  // One cycle in which thread tid is expected to be fetched.
  task automatic expect_issue(input int tid);
    step();
    chk("if_valid", {31'd0, if_valid}, 32'd1);
    chk("if_thread", {29'd0, if_thread}, tid);
    chk("if_pc", if_pc, exp_pc[tid]);
    exp_pc[tid] = exp_pc[tid] + 32'd4;
  endtask

  task automatic run_seq();
    foreach (seq[k]) expect_issue(seq[k]);
  endtask

  function automatic logic [31:0] pc_of(input int t);
    return pc_flat[32*t +: 32];
  endfunction

  initial begin
    rst = 1'b0; stalled = '0; miss_en = 1'b0; miss_thread = '0; miss_pc = '0;
    fill_en = 1'b0; wb_pc_en = '0; wb_pc_data = '0; exc_en = 1'b0; exc_thread = '0;
`ifdef SCHED_ISSUE_CNT_EN
    cnt_sel = 3'd2;
`endif
    reset_model();
    step(); step();
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_thread", {29'd0, if_thread}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_waiting", {24'd0, waiting}, 32'd0);
    for (int t = 0; t < N; t++) chk("rst_pc", pc_of(t), 32'h1000);
    rst = 1'b1;

    // plain round robin, thread 0 first
    seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    run_seq();
    chk("pc0_after_rr", pc_of(0), 32'h1008);
    chk("pc2_after_rr", pc_of(2), 32'h1004);

    // threads 1 and 2 stalled, then released
    stalled = 8'b0000_0110;
    seq = '{3, 4, 5, 6, 7, 0, 3};
    run_seq();
    stalled = '0;
    seq = '{4, 5, 6, 7, 0, 1, 2};
    run_seq();

    // miss on thread 3 (would have been next)
    miss_en = 1'b1; miss_thread = 3'd3; miss_pc = 32'h1008;
    expect_issue(4);
    exp_pc[3] = 32'h1008;
    miss_en = 1'b0;
    chk("miss_waiting", {24'd0, waiting}, 32'h08);
    chk("miss_pc3", pc_of(3), 32'h1008);
    seq = '{5, 6, 7, 0, 1, 2, 4};
    run_seq();
    chk("miss_still_waiting", {24'd0, waiting}, 32'h08);
    fill_en = 1'b1;
    expect_issue(5);
    fill_en = 1'b0;
    chk("fill_waiting", {24'd0, waiting}, 32'd0);
    seq = '{6, 7, 0, 1, 2, 3, 4};
    run_seq();

    // exception and redirect together on thread 5: exception wins
    exc_en = 1'b1; exc_thread = 3'd5; wb_pc_en = 8'b0010_0000; wb_pc_data = 32'h3000;
    expect_issue(6);
    exc_en = 1'b0; wb_pc_en = '0;
    exp_pc[5] = 32'h2000;
    chk("exc_pc5", pc_of(5), 32'h2000);
    seq = '{7, 0, 1, 2, 3, 4, 5};
    run_seq();

    // multi-bit redirect to threads 0 and 7
    wb_pc_en = 8'b1000_0001; wb_pc_data = 32'h4000;
    expect_issue(6);
    wb_pc_en = '0;
    exp_pc[0] = 32'h4000; exp_pc[7] = 32'h4000;
    chk("wb_pc0", pc_of(0), 32'h4000);
    chk("wb_pc7", pc_of(7), 32'h4000);
    seq = '{7, 0};
    run_seq();

    // exception beats miss on thread 1: thread stays RUN at EXC_VECTOR
    exc_en = 1'b1; exc_thread = 3'd1; miss_en = 1'b1; miss_thread = 3'd1; miss_pc = 32'h5000;
    expect_issue(2);
    exc_en = 1'b0; miss_en = 1'b0;
    exp_pc[1] = 32'h2000;
    chk("excmiss_waiting", {24'd0, waiting}, 32'd0);
    chk("excmiss_pc1", pc_of(1), 32'h2000);
    seq = '{3, 4, 5, 6, 7, 0, 1};
    run_seq();

    // fill and miss for thread 2 in the same cycle: thread waits
    miss_en = 1'b1; miss_thread = 3'd2; miss_pc = 32'h6000; fill_en = 1'b1;
    expect_issue(3);
    miss_en = 1'b0; fill_en = 1'b0;
    exp_pc[2] = 32'h6000;
    chk("fillmiss_waiting", {24'd0, waiting}, 32'h04);
    fill_en = 1'b1;
    expect_issue(4);
    fill_en = 1'b0;
    chk("fill2_waiting", {24'd0, waiting}, 32'd0);
    seq = '{5, 6, 7, 0, 1, 2};
    run_seq();

    // everything stalled for three cycles
    stalled = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("allstall_valid", {31'd0, if_valid}, 32'd0);
    end
    chk("allstall_pc3", pc_of(3), exp_pc[3]);
    stalled = '0;
    seq = '{3, 4};
    run_seq();

    // async reset mid-run with a miss in flight
    miss_en = 1'b1; miss_thread = 3'd6; miss_pc = 32'h7000;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_pc6", pc_of(6), 32'h1000);
    step();
    chk("arst_waiting", {24'd0, waiting}, 32'd0);
    miss_en = 1'b0;
    rst = 1'b1;
    reset_model();
    seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
    run_seq();

`ifdef SCHED_ISSUE_CNT_EN
    chk("cnt_val_2", cnt_val, 32'd2);
    rst = 1'b0;
    #1;
    chk("cnt_val_rst", cnt_val, 32'd0);
    chk("cnt_rst_valid", {31'd0, if_valid}, 32'd0);
    step();
    rst = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
- Per-thread PC owner and fetch arbiter for the N_THREADS-way fine-grained multithreaded pipeline.
- Each cycle it picks one ready thread round-robin, presents its thread id and PC to stage IF, and advances that PC by 4 speculatively.
- It also absorbs redirects from stage WB, replays i-cache/iTLB misses from stage ID, and applies exceptions.

Parameters:
N_THREADS, 8, number of hardware threads; power of two, 2..8
PC_RESET, 32'h1000, PC of every thread after reset
EXC_VECTOR, 32'h2000, PC loaded on exception
TID_W, $clog2(N_THREADS), thread id width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
stalled  in  N_THREADS  thread blocked by TL (d-cache miss/store); not eligible while 1
miss_en  in  1  ID reports fetch of miss_thread missed (icache or itlb)
miss_thread  in  TID_W  thread whose fetch missed
miss_pc  in  32  PC of the missed fetch
fill_en  in  1  i-cache line delivered; wakes every WAIT_MEM thread
wb_pc_en  in  N_THREADS  one-hot WB redirect (jump/taken branch/iret)
wb_pc_data  in  32  redirect target
exc_en  in  1  exception raised for exc_thread
exc_thread  in  TID_W  faulting thread
if_valid  out  1  registered; if_thread/if_pc valid this cycle
if_thread  out  TID_W  registered; issued thread
if_pc  out  32  registered; PC fetched for if_thread
pc_flat  out  32*N_THREADS  current PC of every thread, thread 0 in LSBs
waiting  out  N_THREADS  thread is in WAIT_MEM

Behaviour:
- Reset (rst=0, async): all pc = PC_RESET; all threads in RUN state; rr pointer = N_THREADS-1, so thread 0 is issued first; if_valid=0, if_thread=0, if_pc=0; waiting=0. Counters (optional feature) = 0.
- Per-thread state: RUN, WAIT_MEM.
  - RUN -> WAIT_MEM on miss_en for that thread.
  - WAIT_MEM -> RUN on fill_en, or on exc_en / wb_pc_en for that thread.
- Eligible(t) = state RUN, stalled[t]=0, and t not the subject of miss_en, exc_en or wb_pc_en this cycle.
- Arbitration: combinational search from rr+1 upward, modulo N_THREADS; the first eligible thread wins.
  - Winner w: if_valid<=1, if_thread<=w, if_pc<=pc[w], pc[w]<=pc[w]+4 (32-bit wrap, no overflow flag), rr<=w.
  - No eligible thread: if_valid<=0; rr and all PCs unchanged.
- PC update priority per thread, highest first:
  1. exc_en: pc=EXC_VECTOR.
  2. wb_pc_en: pc=wb_pc_data.
  3. miss_en: pc=miss_pc (replay).
  4. Issue increment.
- Latency: a redirect or exception in cycle n is visible on pc_flat at n+1; the earliest fetch of the new PC appears on if_pc at n+2.
- fill_en together with miss_en for the same thread: the thread ends in WAIT_MEM (the miss is newer).
- wb_pc_en with more than one bit set: every flagged thread takes wb_pc_data.
- exc_en and miss_en for the same thread: the exception wins and the thread is RUN.
- Reset asserted mid-operation: immediate return to reset values; in-flight requests are discarded.

Optional Feature:
SCHED_ISSUE_CNT_EN:
- Defined: adds input cnt_sel[TID_W] and output cnt_val[32]. Each thread has a 32-bit saturating issue counter, +1 per cycle it is the winner. cnt_val is a registered copy of counter[cnt_sel], one cycle latency. Counters clear on reset only.
- Undefined: neither port nor any counter exists. All other behaviour is identical.

Test Plan:
- Reset, no stalls, 10 cycles -> if_thread 0,1,...,7,0,1; if_pc 0x1000 for the first 8 issues, then 0x1004 for threads 0 and 1.
- stalled=8'b0000_0110 held -> threads 1 and 2 never issued; order 0,3,4,5,6,7,0; release -> thread 1 issued at the next point its turn comes.
- miss_en thread 3, miss_pc=0x1008 -> waiting[3]=1, thread 3 skipped; fill_en -> waiting[3]=0, next issue of thread 3 has if_pc=0x1008.
- Same cycle: exc_en thread 5, wb_pc_en[5]=1, wb_pc_data=0x3000 -> pc[5]=0x2000; thread 5 not issued that cycle.
- All 8 threads stalled for 3 cycles -> if_valid=0 for those cycles; release -> round-robin resumes at rr+1.
- SCHED_ISSUE_CNT_EN defined, 16 unstalled cycles, cnt_sel=2 -> cnt_val=2; rst pulse mid-run -> cnt_val=0, if_valid=0 asynchronously.
